mstage: RTL and testbench

Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage. Captures the execute results (ALU value, store data, destination, opcode, exception code), drives the data-bus request for LB/LBU/LH/LHU/LW/SB/SH/SW, and detects misaligned addresses. It also extends load data and presents the final result to the write-back register. While a bus transaction is outstanding it asserts `m_busy` so the hazard unit can stall the front of the pipe.

---
 rtl/mstage_pkg.sv | 58 +++++
 rtl/mstage_load_ext.sv | 27 ++
 rtl/mstage.sv | 148 ++++++++++++++
 tb/tb_mstage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mstage_pkg.sv
// Shared opcode/exception constants, memory-stage FSM states and the capture-register layout.
// Also holds the small opcode decode helpers used by mstage.
package mstage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  localparam logic [5:0] EXC_ADEL      = 6'b100100;
  localparam logic [5:0] EXC_ADES      = 6'b100101;
  localparam int         EXC_VALID_BIT = 5;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} mstate_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val3;
    logic [31:0] badvaddr;
    logic [31:0] wdata;
    logic [5:0]  icode;
    logic [5:0]  acode;
    logic [5:0]  exc_code;
    logic [4:0]  dst;
    logic        in_delay_slot;
    logic [3:0]  strobe;
    logic [1:0]  size;
  } mreg_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] op_size(input logic [5:0] op);
    if ((op == OP_LB) || (op == OP_LBU) || (op == OP_SB)) return 2'd0;
    if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op_size(op))
      2'd2:    return |a;
      2'd1:    return a[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mstage_load_ext.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it per load opcode.
// Purely combinational; no backpressure.
module load_ext
  import mstage_pkg::*;
(
  input  logic [5:0]  icode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (icode)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'd0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'd0, half_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mstage.sv
// MIPS memory stage: capture register, data-bus request FSM, alignment check, load result mux.
// Request 1 cycle after capture; m_busy stalls upstream until the bus response returns.
module mstage
  import mstage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] M_pc,
  input  logic [31:0] M_val3,
  input  logic [31:0] M_valt,
  input  logic [5:0]  M_icode,
  input  logic [5:0]  M_acode,
  input  logic [5:0]  M_excCode,
  input  logic [4:0]  M_dst,
  input  logic        M_inDelaySlot,
  input  logic        M_stall,
  input  logic        M_bubble,
  input  logic        exception,
  output logic        dreq_valid,
  input  logic        dreq_ready,
  output logic [31:0] dreq_addr,
  output logic [31:0] dreq_data,
  output logic [3:0]  dreq_strobe,
  output logic [1:0]  dreq_size,
  input  logic        dresp_valid,
  input  logic [31:0] dresp_data,
  output logic [31:0] m_pc,
  output logic [31:0] m_val4,
  output logic [31:0] m_badvaddr,
  output logic [5:0]  m_icode,
  output logic [5:0]  m_acode,
  output logic [5:0]  m_excCode,
  output logic [4:0]  m_dst,
  output logic        m_inDelaySlot,
  output logic        m_busy
);

  mreg_t       r;
  mreg_t       cap;
  mstate_t     state;
  logic        flush_pend;
  logic [31:0] load_buf;
  logic [31:0] ext_data;

  always_comb begin
    cap               = '0;
    cap.pc            = M_pc;
    cap.exc_code      = M_excCode;
    cap.in_delay_slot = M_inDelaySlot;
    if (!M_excCode[EXC_VALID_BIT]) begin
      cap.val3  = M_val3;
      cap.acode = M_acode;
      if ((is_load(M_icode) || is_store(M_icode)) && misaligned(M_icode, M_val3[1:0])) begin
        cap.exc_code = is_store(M_icode) ? EXC_ADES : EXC_ADEL;
        cap.badvaddr = M_val3;
      end else begin
        cap.icode = M_icode;
        cap.dst   = M_dst;
        if (is_load(M_icode) || is_store(M_icode)) cap.size = op_size(M_icode);
        if (is_store(M_icode)) begin
          case (op_size(M_icode))
            2'd0: begin
              cap.wdata  = {4{M_valt[7:0]}};
              cap.strobe = 4'b0001 << M_val3[1:0];
            end
            2'd1: begin
              cap.wdata  = {2{M_valt[15:0]}};
              cap.strobe = 4'b0011 << M_val3[1:0];
            end
            default: begin
              cap.wdata  = M_valt;
              cap.strobe = 4'b1111;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r          <= '0;
      state      <= S_IDLE;
      flush_pend <= 1'b0;
      load_buf   <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (dreq_ready) begin
            state      <= S_WAIT;
            flush_pend <= exception;
          end else if (exception) begin
            r     <= '0;
            state <= S_IDLE;
          end
        end
        // A flushed transaction still has to drain its response before the stage frees up.
        S_WAIT: begin
          if (dresp_valid) begin
            if (flush_pend || exception) begin
              r     <= '0;
              state <= S_IDLE;
            end else begin
              load_buf <= dresp_data;
              state    <= S_DONE;
            end
          end else if (exception) begin
            flush_pend <= 1'b1;
          end
        end
        default: begin
          if (!M_stall) begin
            if (M_bubble || exception) begin
              r     <= '0;
              state <= S_IDLE;
            end else begin
              r     <= cap;
              state <= (is_load(cap.icode) || is_store(cap.icode)) ? S_REQ : S_IDLE;
            end
          end
        end
      endcase
    end
  end

  load_ext u_load_ext (
    .icode   (r.icode),
    .addr_lo (r.val3[1:0]),
    .raw     (load_buf),
    .data    (ext_data)
  );

  assign m_busy        = (state == S_REQ) || (state == S_WAIT);
  assign dreq_valid    = (state == S_REQ);
  assign dreq_addr     = r.val3;
  assign dreq_data     = r.wdata;
  assign dreq_strobe   = r.strobe;
  assign dreq_size     = r.size;
  assign m_pc          = r.pc;
  assign m_val4        = is_load(r.icode) ? ext_data : r.val3;
  assign m_badvaddr    = r.badvaddr;
  assign m_icode       = r.icode;
  assign m_acode       = r.acode;
  assign m_excCode     = r.exc_code;
  assign m_dst         = r.dst;
  assign m_inDelaySlot = r.in_delay_slot;

endmodule

// File: tb/tb_mstage.sv
// Randomized bench for mstage: the bench acts as the data bus and predicts every output
// from a transaction-level model of the memory stage.
module tb_mstage;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2b;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] M_pc, M_val3, M_valt;
  logic [5:0]  M_icode, M_acode, M_excCode;
  logic [4:0]  M_dst;
  logic        M_inDelaySlot, M_stall, M_bubble, exception;
  logic        dreq_valid, dreq_ready;
  logic [31:0] dreq_addr, dreq_data;
  logic [3:0]  dreq_strobe;
  logic [1:0]  dreq_size;
  logic        dresp_valid;
  logic [31:0] dresp_data;
  logic [31:0] m_pc, m_val4, m_badvaddr;
  logic [5:0]  m_icode, m_acode, m_excCode;
  logic [4:0]  m_dst;
  logic        m_inDelaySlot, m_busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_pc;

  always #5 clk = ~clk;

  mstage dut (
    .clk(clk), .resetn(resetn),
    .M_pc(M_pc), .M_val3(M_val3), .M_valt(M_valt),
    .M_icode(M_icode), .M_acode(M_acode), .M_excCode(M_excCode), .M_dst(M_dst),
    .M_inDelaySlot(M_inDelaySlot), .M_stall(M_stall), .M_bubble(M_bubble),
    .exception(exception),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
    .dreq_data(dreq_data), .dreq_strobe(dreq_strobe), .dreq_size(dreq_size),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .m_pc(m_pc), .m_val4(m_val4), .m_badvaddr(m_badvaddr),
    .m_icode(m_icode), .m_acode(m_acode), .m_excCode(m_excCode), .m_dst(m_dst),
    .m_inDelaySlot(m_inDelaySlot), .m_busy(m_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int op_bytes(input logic [5:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * (addr % 4));
    case (op)
      LB:      return {{24{v[7]}}, v[7:0]};
      LBU:     return v & 32'h0000_00ff;
      LH:      return {{16{v[15]}}, v[15:0]};
      LHU:     return v & 32'h0000_ffff;
      default: return word;
    endcase
  endfunction

  task automatic scramble_inputs();
    M_pc = $urandom; M_val3 = $urandom; M_valt = $urandom;
    M_icode = 6'($urandom); M_acode = 6'($urandom); M_dst = 5'($urandom);
    M_excCode = 6'($urandom); M_inDelaySlot = 1'($urandom);
  endtask

  // flush: 0 none, 1 flush while the request waits for ready, 2 flush while waiting for data
  task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] valt,
                       input logic [5:0] exc, input int rdy_dly, input int resp_dly,
                       input logic [31:0] rword, input int flush);
    logic [31:0] pc, e_bad, e_val4, e_data;
    logic [5:0]  ac, e_exc, e_ic, e_ac;
    logic [4:0]  dst, e_dst;
    logic [3:0]  e_strb;
    logic        ds;
    int          nb;
    bit          mis, mem;
    pc = $urandom; ac = 6'($urandom); dst = 5'($urandom); ds = 1'($urandom);
    nb  = op_bytes(op);
    mis = (nb > 0) && ((addr % nb) != 0);
    mem = !exc[5] && (nb > 0) && !mis;
    e_exc = exc; e_ic = op; e_ac = ac; e_dst = dst; e_bad = 0; e_val4 = addr;
    if (exc[5]) begin
      e_ic = 0; e_ac = 0; e_dst = 0;
    end else if (mis) begin
      e_exc = op_store(op) ? 6'b100101 : 6'b100100;
      e_bad = addr; e_ic = 0; e_dst = 0;
    end
    e_strb = op_store(op) ? 4'(((1 << nb) - 1) << (addr % 4)) : 4'b0000;
    e_data = (nb == 1) ? valt[7:0] * 32'h0101_0101 :
             (nb == 2) ? valt[15:0] * 32'h0001_0001 : valt;
    if (!op_store(op)) e_data = 0;

    M_pc = pc; M_val3 = addr; M_valt = valt; M_icode = op; M_acode = ac;
    M_excCode = exc; M_dst = dst; M_inDelaySlot = ds;
    M_stall = 1'b0; M_bubble = 1'b0; exception = 1'b0;
    @(negedge clk);
    M_stall = 1'b1;
    scramble_inputs();
    chk("cap_pc", m_pc, pc);
    chk("cap_exc", 32'(m_excCode), 32'(e_exc));
    chk("cap_icode", 32'(m_icode), 32'(e_ic));
    chk("cap_dst", 32'(m_dst), 32'(e_dst));
    chk("cap_ds", 32'(m_inDelaySlot), 32'(ds));
    chk("cap_badv", m_badvaddr, e_bad);
    if (!exc[5]) chk("cap_acode", 32'(m_acode), 32'(e_ac));
    if (!mem) begin
      chk("nomem_busy", 32'(m_busy), 0);
      chk("nomem_req", 32'(dreq_valid), 0);
      if (!exc[5]) chk("nomem_val4", m_val4, e_val4);
      @(negedge clk);
      chk("nomem_req2", 32'(dreq_valid), 0);
      last_pc = pc;
      return;
    end
    chk("req_busy", 32'(m_busy), 1);
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("req_vld", 32'(dreq_valid), 1);
      chk("req_addr", dreq_addr, addr);
      chk("req_strb", 32'(dreq_strobe), 32'(e_strb));
      chk("req_size", 32'(dreq_size), (nb == 1) ? 0 : (nb == 2) ? 1 : 2);
      if (op_store(op)) chk("req_data", dreq_data, e_data);
      if (i < rdy_dly) begin
        dresp_valid = 1'($urandom);
        dresp_data = $urandom;
        @(negedge clk);
        dresp_valid = 1'b0;
      end
    end
    if (flush == 1) begin
      exception = 1'b1;
      @(negedge clk);
      exception = 1'b0;
      chk("flreq_vld", 32'(dreq_valid), 0);
      chk("flreq_busy", 32'(m_busy), 0);
      chk("flreq_pc", m_pc, 0);
      chk("flreq_icode", 32'(m_icode), 0);
      last_pc = 0;
      return;
    end
    dreq_ready = 1'b1;
    @(negedge clk);
    dreq_ready = 1'b0;
    chk("wait_vld", 32'(dreq_valid), 0);
    chk("wait_busy", 32'(m_busy), 1);
    for (int i = 0; i <= resp_dly; i++) begin
      if (flush == 2) exception = (i == 0);
      if (i == resp_dly) begin
        dresp_valid = 1'b1;
        dresp_data = rword;
      end
      @(negedge clk);
      exception = 1'b0;
      dresp_valid = 1'b0;
      dresp_data = $urandom;
      chk("wait_busy_n", 32'(m_busy), (i < resp_dly) ? 1 : 0);
    end
    if (flush == 2) begin
      chk("flwait_pc", m_pc, 0);
      chk("flwait_icode", 32'(m_icode), 0);
      chk("flwait_val4", m_val4, 0);
      last_pc = 0;
    end else begin
      chk("done_val4", m_val4, op_store(op) ? addr : ref_load(op, addr, rword));
      chk("done_pc", m_pc, pc);
      chk("done_icode", 32'(m_icode), 32'(op));
      last_pc = pc;
    end
  endtask

  function automatic logic [5:0] pick_op(input int k);
    case (k)
      0: return LB;  1: return LBU; 2: return LH;  3: return LHU; 4: return LW;
      5: return SB;  6: return SH;  7: return SW;  8: return 6'h09; 9: return 6'h0f;
      default: return 6'h00;
    endcase
  endfunction

  initial begin
    resetn = 1'b0; M_stall = 1'b0; M_bubble = 1'b0; exception = 1'b0;
    dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_data = 0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    chk("rst_pc", m_pc, 0);
    chk("rst_val4", m_val4, 0);
    chk("rst_busy", 32'(m_busy), 0);
    chk("rst_req", 32'(dreq_valid), 0);
    chk("rst_exc", 32'(m_excCode), 0);
    chk("rst_strb", 32'(dreq_strobe), 0);
    resetn = 1'b1;

    do_op(SW, 32'h8000_0010, 32'h1234_5678, 0, 2, 1, 32'h0, 0);
    do_op(LB, 32'h8000_0003, 32'h0, 0, 0, 0, 32'h80FF_0000, 0);
    chk("lb_sign", m_val4, 32'hFFFF_FF80);
    do_op(LBU, 32'h8000_0003, 32'h0, 0, 1, 2, 32'h80FF_0000, 0);
    chk("lbu_zero", m_val4, 32'h0000_0080);
    do_op(SH, 32'h8000_0002, 32'h0000_ABCD, 0, 0, 0, 32'h0, 0);
    do_op(LH, 32'h8000_0001, 32'h0, 0, 0, 0, 32'h0, 0);
    do_op(LW, 32'h8000_0020, 32'h0, 6'b101100, 0, 0, 32'h0, 0);
    do_op(LW, 32'h8000_0024, 32'h0, 0, 1, 0, 32'h0, 1);
    do_op(LW, 32'h8000_0028, 32'h0, 0, 0, 2, 32'hdead_beef, 2);
    do_op(LHU, 32'h8000_0006, 32'h0, 0, 0, 0, 32'h8765_4321, 0);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op, exc;
      int fl, r;
      op  = pick_op($urandom_range(0, 10));
      exc = ($urandom_range(0, 9) == 0) ? {1'b1, 5'($urandom)} : 6'd0;
      r   = $urandom_range(0, 7);
      fl  = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      do_op(op, $urandom, $urandom, exc, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom, fl);
    end

    // Stall holds the register, bubble then clears it.
    do_op(6'h09, 32'h0000_1234, 32'h0, 0, 0, 0, 32'h0, 0);
    repeat (3) begin
      scramble_inputs();
      @(negedge clk);
      chk("stall_hold_pc", m_pc, last_pc);
      chk("stall_hold_val4", m_val4, 32'h0000_1234);
    end
    M_stall = 1'b0; M_bubble = 1'b1;
    @(negedge clk);
    M_bubble = 1'b0; M_stall = 1'b1;
    chk("bubble_pc", m_pc, 0);
    chk("bubble_icode", 32'(m_icode), 0);
    chk("bubble_val4", m_val4, 0);

    // Reset in the middle of a transaction returns to idle; the late response is ignored.
    M_pc = 32'h44; M_val3 = 32'h8000_0040; M_icode = LW; M_excCode = 0;
    M_stall = 1'b0;
    @(negedge clk);
    M_stall = 1'b1;
    dreq_ready = 1'b1;
    @(negedge clk);
    dreq_ready = 1'b0;
    chk("rstmid_busy_pre", 32'(m_busy), 1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rstmid_busy", 32'(m_busy), 0);
    chk("rstmid_pc", m_pc, 0);
    dresp_valid = 1'b1; dresp_data = 32'hffff_ffff;
    @(negedge clk);
    dresp_valid = 1'b0;
    chk("rstmid_resp_ign", 32'(m_busy), 0);
    chk("rstmid_val4", m_val4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
